axi_ar_issue: RTL

//  Read side of the iDMA address FIFO: pops {addr, beat_count} descriptors and issues AXI4 INCR read

---
 rtl/idma_axi_pkg.sv | 14 +
 rtl/idma_burst_calc.sv | 29 ++
 rtl/axi_ar_issue.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/idma_axi_pkg.sv
// Shared iDMA AXI definitions: issuer FSM encoding and AXI protocol constants.
// Imported by the read-side and write-side address issuers.
package idma_axi_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StAddr = 2'd2
  } state_e;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam int unsigned AXI_4K_BYTES   = 4096;

endpackage

// File: rtl/idma_burst_calc.sv
// Combinational burst sizing: beats for the next burst given the page offset and remaining beats.
// Result is min(rem_beats, MAX_BURST, beats left before the next 4KB boundary).
module idma_burst_calc
  import idma_axi_pkg::*;
#(
  parameter int unsigned LEN_W      = 32,
  parameter int unsigned DATA_BYTES = 8,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic [11:0]      page_off_i,
  input  logic [LEN_W-1:0] rem_beats_i,
  output logic [8:0]       n_o
);

  localparam int unsigned SizeLog = $clog2(DATA_BYTES);

  logic [12:0] page_bytes;
  logic [12:0] page_beats;
  logic [12:0] cap;

  always_comb begin
    // Offset is beat aligned, so the shift is exact.
    page_bytes = 13'(AXI_4K_BYTES) - {1'b0, page_off_i};
    page_beats = page_bytes >> SizeLog;
    cap        = (page_beats < 13'(MAX_BURST)) ? page_beats : 13'(MAX_BURST);
    n_o        = (rem_beats_i < LEN_W'(cap)) ? 9'(rem_beats_i) : 9'(cap);
  end

endmodule

// File: rtl/axi_ar_issue.sv
// Read-side iDMA address issuer: pops descriptors from the address FIFO and issues
// 4KB-safe AXI4 INCR read bursts, limiting outstanding bursts by counting RLAST.
module axi_ar_issue
  import idma_axi_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LEN_W      = 32,
  parameter int unsigned DATA_BYTES = 8,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned MAX_OSTD   = 8,
  parameter int unsigned OSTD_W     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    init,
  input  logic                    addr_fifo_empty,
  input  logic [ADDR_W+LEN_W-1:0] addr_fifo_data_out,
  output logic                    addr_fifo_pop,
  output logic [ADDR_W-1:0]       araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic                    rvalid,
  input  logic                    rready,
  input  logic                    rlast,
  output logic [OSTD_W-1:0]       ostd_cnt,
  output logic                    busy,
  output logic                    err_zero_len
);

  localparam int unsigned      SizeLog  = $clog2(DATA_BYTES);
  localparam logic [ADDR_W-1:0] BeatMask = ADDR_W'(DATA_BYTES - 1);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [8:0]         n_q, n_d;
  logic [ADDR_W-1:0]  araddr_q, araddr_d;
  logic [7:0]         arlen_q, arlen_d;
  logic               drop_q, drop_d;
  logic               err_q, err_d;
  logic [OSTD_W-1:0]  ostd_q, ostd_d;

  logic [ADDR_W-1:0]  fifo_addr;
  logic [LEN_W-1:0]   fifo_beats;
  logic [8:0]         calc_n;
  logic               ar_hs;
  logic               r_done;

  assign fifo_addr  = addr_fifo_data_out[ADDR_W+LEN_W-1:LEN_W];
  assign fifo_beats = addr_fifo_data_out[LEN_W-1:0];

  idma_burst_calc #(
    .LEN_W      (LEN_W),
    .DATA_BYTES (DATA_BYTES),
    .MAX_BURST  (MAX_BURST)
  ) u_burst_calc (
    .page_off_i  (addr_q[11:0]),
    .rem_beats_i (rem_q),
    .n_o         (calc_n)
  );

  assign arvalid      = (state_q == StAddr);
  assign araddr       = araddr_q;
  assign arlen        = arlen_q;
  assign arsize       = 3'(SizeLog);
  assign arburst      = AXI_BURST_INCR;
  assign ostd_cnt     = ostd_q;
  assign busy         = (state_q != StIdle) || (ostd_q != '0);
  assign err_zero_len = err_q;

  assign ar_hs  = arvalid && arready;
  assign r_done = rvalid && rready && rlast;

  always_comb begin
    ostd_d = ostd_q;
    if (ar_hs && !r_done) begin
      ostd_d = ostd_q + OSTD_W'(1);
    end else if (!ar_hs && r_done && (ostd_q != '0)) begin
      ostd_d = ostd_q - OSTD_W'(1);
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    rem_d         = rem_q;
    n_d           = n_q;
    araddr_d      = araddr_q;
    arlen_d       = arlen_q;
    drop_d        = drop_q;
    err_d         = 1'b0;
    addr_fifo_pop = 1'b0;

    unique case (state_q)
      StIdle: begin
        drop_d = 1'b0;
        if (!addr_fifo_empty && !init && !rst) begin
          addr_fifo_pop = 1'b1;
          addr_d        = fifo_addr & ~BeatMask;
          rem_d         = fifo_beats;
          if (fifo_beats == '0) begin
            err_d = 1'b1;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        if (init) begin
          state_d = StIdle;
        end else begin
          n_d      = calc_n;
          araddr_d = addr_q;
          arlen_d  = 8'(calc_n - 9'd1);
          if (ostd_q < OSTD_W'(MAX_OSTD)) begin
            state_d = StAddr;
          end
        end
      end
      StAddr: begin
        // A soft clear here must not withdraw arvalid; remember it until the handshake.
        if (init) begin
          drop_d = 1'b1;
        end
        if (arready) begin
          addr_d = addr_q + (ADDR_W'(n_q) << SizeLog);
          rem_d  = rem_q - LEN_W'(n_q);
          if ((rem_d == '0) || init || drop_q) begin
            state_d = StIdle;
          end else begin
            state_d = StCalc;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      rem_q    <= '0;
      n_q      <= '0;
      araddr_q <= '0;
      arlen_q  <= '0;
      drop_q   <= 1'b0;
      err_q    <= 1'b0;
      ostd_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      n_q      <= n_d;
      araddr_q <= araddr_d;
      arlen_q  <= arlen_d;
      drop_q   <= drop_d;
      err_q    <= err_d;
      ostd_q   <= ostd_d;
    end
  end

endmodule
